// File: rtl/noc_arb_pkg.sv
// Shared types, port indices and the round-robin pick helper for the
// per-output-port wormhole arbiter of the 5-port XY mesh router.
package noc_arb_pkg;

    // Arbiter FSM: IDLE spends one arbitration bubble, LOCKED holds the packet.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Router input indices.
    localparam int unsigned LOCAL = 32'd0;
    localparam int unsigned NORTH = 32'd1;
    localparam int unsigned EAST  = 32'd2;
    localparam int unsigned SOUTH = 32'd3;
    localparam int unsigned WEST  = 32'd4;

    // Widest request vector rr_pick handles; callers pad narrower vectors.
    localparam int unsigned RR_MAX_PORTS = 32'd16;

    // One-hot pick of the first set bit at or after ptr, wrapping from
    // n_ports-1 back to 0. Returns all-zero when no bit is set.
    function automatic logic [RR_MAX_PORTS-1:0] rr_pick(
        input logic [RR_MAX_PORTS-1:0] req_vec,
        input int unsigned             ptr,
        input int unsigned             n_ports
    );
        logic [RR_MAX_PORTS-1:0] pick;
        logic                    found;
        int unsigned             idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_PORTS; k++) begin
            idx = ptr + k;
            if (idx >= n_ports) begin
                idx = idx - n_ports;
            end else begin
                idx = idx;
            end
            if ((k < n_ports) && !found && req_vec[idx[3:0]]) begin
                pick[idx[3:0]] = 1'b1;
                found          = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick plus the rotating priority pointer.
// The pick is purely combinational; the pointer advances to the slot after
// the released grant when upd_en is pulsed. Supports up to RR_MAX_PORTS.
module rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = 5,
    localparam int unsigned PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic               upd_en,
    input  logic [N_PORTS-1:0] upd_grant,
    output logic [N_PORTS-1:0] pick,
    output logic [PTR_W-1:0]   rr_ptr
);

    logic [PTR_W-1:0]        rr_ptr_q;
    logic [PTR_W-1:0]        rr_ptr_d;
    logic [RR_MAX_PORTS-1:0] req_pad_s;
    logic [RR_MAX_PORTS-1:0] pick_full_s;
    logic                    pick_full_unused_s;

    // Pad the request vector and pick the next requester from the pointer.
    always_comb begin
        req_pad_s                = '0;
        req_pad_s[N_PORTS-1:0]   = req;
        pick_full_s              = rr_pick(req_pad_s, 32'(rr_ptr_q), N_PORTS);
        pick                     = pick_full_s[N_PORTS-1:0];
        pick_full_unused_s       = ^pick_full_s;
    end

    // Next pointer: slot after the released grant, wrapping at N_PORTS.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (upd_en) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (upd_grant[i]) begin
                    rr_ptr_d = (i == N_PORTS - 1) ? '0 : PTR_W'(i + 1);
                end else begin
                    rr_ptr_d = rr_ptr_d;
                end
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/noc_port_arbiter.sv
// Per-output-port wormhole arbiter and AXI-Stream mux. One input is
// granted round-robin, the grant is locked for the whole packet and
// released on the TLAST handshake. The data/ready path through a locked
// grant is combinational so flits see no added latency.
// Optional build macro NOC_ARB_PMU_EN adds per-input packet and stall
// counters readable through pmu_sel/pmu_pkts/pmu_stall.
module noc_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned N_PORTS    = 5,
    parameter int unsigned DATA_WIDTH = 40,
    parameter int unsigned PMU_CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req,
    input  logic [N_PORTS-1:0]            s_tvalid,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_PORTS-1:0]            s_tlast,
    output logic [N_PORTS-1:0]            s_tready,
    output logic                          m_tvalid,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [N_PORTS-1:0]            grant,
    output logic                          busy,
    input  logic [$clog2(N_PORTS)-1:0]    pmu_sel,
    output logic [PMU_CNT_W-1:0]          pmu_pkts,
    output logic [PMU_CNT_W-1:0]          pmu_stall
);

    localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [N_PORTS-1:0] grant_q;
    logic [N_PORTS-1:0] grant_d;
    logic [N_PORTS-1:0] cand_s;
    logic [N_PORTS-1:0] pick_s;
    logic               rr_upd_s;
    logic [PTR_W-1:0]   rr_ptr_unused_s;
    logic               locked_s;
    logic               beat_s;
    logic               last_beat_s;

    // Only inputs that both route here and present a flit may compete.
    assign cand_s = req & s_tvalid;

    rr_arbiter #(
        .N_PORTS (N_PORTS)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (cand_s),
        .upd_en    (rr_upd_s),
        .upd_grant (grant_q),
        .pick      (pick_s),
        .rr_ptr    (rr_ptr_unused_s)
    );

    // Granted-port handshake decode; grant_q is non-zero only while LOCKED.
    always_comb begin
        locked_s    = (state_q == LOCKED);
        beat_s      = locked_s & (|(grant_q & s_tvalid)) & m_tready;
        last_beat_s = locked_s & (|(grant_q & s_tvalid & s_tlast)) & m_tready;
    end

    // Next-state logic: lock on a pick, release on the TLAST handshake.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_upd_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (|cand_s) begin
                    grant_d = pick_s;
                    state_d = LOCKED;
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (last_beat_s) begin
                    grant_d  = '0;
                    state_d  = IDLE;
                    rr_upd_s = 1'b1;
                end else begin
                    grant_d = grant_q;
                    state_d = LOCKED;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and grant registers; reset drops any lock at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Output mux and ready steering from the locked grant (never from m_tready for valid).
    always_comb begin
        m_tdata  = '0;
        m_tvalid = locked_s & (|(grant_q & s_tvalid));
        m_tlast  = locked_s & (|(grant_q & s_tlast));
        s_tready = locked_s ? (grant_q & {N_PORTS{m_tready}}) : '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                m_tdata = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                m_tdata = m_tdata;
            end
        end
    end

    assign grant = grant_q;
    assign busy  = locked_s;

`ifdef NOC_ARB_PMU_EN
    localparam logic [PMU_CNT_W-1:0] CNT_ONE = PMU_CNT_W'(1);

    logic [PMU_CNT_W-1:0] pkt_cnt_q   [N_PORTS];
    logic [PMU_CNT_W-1:0] pkt_cnt_d   [N_PORTS];
    logic [PMU_CNT_W-1:0] stall_cnt_q [N_PORTS];
    logic [PMU_CNT_W-1:0] stall_cnt_d [N_PORTS];
    logic [PMU_CNT_W-1:0] pmu_pkts_q;
    logic [PMU_CNT_W-1:0] pmu_pkts_d;
    logic [PMU_CNT_W-1:0] pmu_stall_q;
    logic [PMU_CNT_W-1:0] pmu_stall_d;
    logic [N_PORTS-1:0]   xfer_s;

    // Saturating per-input packet and stall counters plus the selected read.
    always_comb begin
        xfer_s = locked_s ? (grant_q & s_tvalid & {N_PORTS{m_tready}}) : '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            pkt_cnt_d[i]   = pkt_cnt_q[i];
            stall_cnt_d[i] = stall_cnt_q[i];
            if (xfer_s[i] && s_tlast[i] && !(&pkt_cnt_q[i])) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + CNT_ONE;
            end else begin
                pkt_cnt_d[i] = pkt_cnt_q[i];
            end
            if (cand_s[i] && !xfer_s[i] && !(&stall_cnt_q[i])) begin
                stall_cnt_d[i] = stall_cnt_q[i] + CNT_ONE;
            end else begin
                stall_cnt_d[i] = stall_cnt_q[i];
            end
        end
        if (32'(pmu_sel) < N_PORTS) begin
            pmu_pkts_d  = pkt_cnt_q[pmu_sel];
            pmu_stall_d = stall_cnt_q[pmu_sel];
        end else begin
            pmu_pkts_d  = '0;
            pmu_stall_d = '0;
        end
    end

    // Counter and read-back registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                pkt_cnt_q[i]   <= '0;
                stall_cnt_q[i] <= '0;
            end
            pmu_pkts_q  <= '0;
            pmu_stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                pkt_cnt_q[i]   <= pkt_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
            pmu_pkts_q  <= pmu_pkts_d;
            pmu_stall_q <= pmu_stall_d;
        end
    end

    assign pmu_pkts  = pmu_pkts_q;
    assign pmu_stall = pmu_stall_q;
`else
    logic pmu_sel_unused_s;

    assign pmu_sel_unused_s = ^pmu_sel;
    assign pmu_pkts         = '0;
    assign pmu_stall        = '0;
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: scenario tasks drive traffic and
// push expected beats into a scoreboard that a negedge monitor drains.
module tb_noc_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    s_tvalid;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic            m_tready;
    logic [N-1:0]    grant;
    logic            busy;
    logic [2:0]      pmu_sel;
    logic [31:0]     pmu_pkts;
    logic [31:0]     pmu_stall;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_cnt = 0;

    always #5 clk = ~clk;

    noc_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant     (grant),
        .busy      (busy),
        .pmu_sel   (pmu_sel),
        .pmu_pkts  (pmu_pkts),
        .pmu_stall (pmu_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int p, input logic [DW-1:0] d, input logic l);
        req[p]              = 1'b1;
        s_tvalid[p]         = 1'b1;
        s_tdata[p*DW +: DW] = d;
        s_tlast[p]          = l;
    endtask

    task automatic clr_port(input int p);
        req[p]              = 1'b0;
        s_tvalid[p]         = 1'b0;
        s_tlast[p]          = 1'b0;
        s_tdata[p*DW +: DW] = '0;
    endtask

    task automatic clr_all();
        for (int i = 0; i < N; i++) clr_port(i);
    endtask

    task automatic push_exp(input int p, input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.port = p;
        e.data = d;
        e.last = l;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for the current flit of port p to be accepted; returns
    // just after the accepting clock edge. Must be called before the negedge.
    task automatic wait_hs(input int p, input string name);
        bit done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_tready[p] && s_tvalid[p]) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: handshake on port %0d got none in 20 cycles, required one", name, p);
        end else begin
            tick();
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected beats still pending, required 0", name, sb_q.size());
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        m_tready = 1'b1;
        clr_all();
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        m_tready = 1'b1;
        pmu_sel  = 3'd0;
        clr_all();
        set_flit(0, 40'h00_0000_00AA, 1'b1);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b m_tvalid=%b s_tready=%b, required 00000 0 0 00000",
                     grant, busy, m_tvalid, s_tready);
        end
`ifndef NOC_ARB_PMU_EN
        checks++;
        if (pmu_pkts !== 32'd0 || pmu_stall !== 32'd0) begin
            errors++;
            $display("FAIL pmu_tied_off: pkts=%0d stall=%0d, required 0 0", pmu_pkts, pmu_stall);
        end
`endif
        tick();
        clr_all();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_single();
        do_reset();
        set_flit(2, 40'h01, 1'b0);
        push_exp(2, 40'h01, 1'b0);
        push_exp(2, 40'h02, 1'b0);
        push_exp(2, 40'h03, 1'b1);
        @(negedge clk);
        checks++;
        if (grant !== 5'b00000 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_bubble: grant=%b m_tvalid=%b, required 00000 0", grant, m_tvalid);
        end
        tick();
        #2;
        checks++;
        if (grant !== 5'b00100 || busy !== 1'b1 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b busy=%b m_tvalid=%b, required 00100 1 1", grant, busy, m_tvalid);
        end
        wait_hs(2, "single_f1");
        set_flit(2, 40'h02, 1'b0);
        wait_hs(2, "single_f2");
        set_flit(2, 40'h03, 1'b1);
        wait_hs(2, "single_f3");
        clr_port(2);
        @(negedge clk);
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%b busy=%b, required 00000 0", grant, busy);
        end
        tick();
        // Pointer should now sit at 3: ports 0, 2 and 3 compete, 3 wins.
        set_flit(0, 40'hA0, 1'b1);
        set_flit(2, 40'h22, 1'b1);
        set_flit(3, 40'h33, 1'b1);
        push_exp(3, 40'h33, 1'b1);
        @(negedge clk);
        tick();
        #2;
        checks++;
        if (grant !== 5'b01000) begin
            errors++;
            $display("FAIL single_rr_ptr: grant=%b, required 01000", grant);
        end
        wait_hs(3, "single_ptr_hs");
        clr_all();
        check_sb_empty("single_sb");
    endtask

    task automatic test_all_rr();
        int h0;
        do_reset();
        for (int i = 0; i < N; i++) set_flit(i, 40'h10 + 40'(i), 1'b1);
        for (int i = 0; i < N; i++) push_exp(i, 40'h10 + 40'(i), 1'b1);
        push_exp(0, 40'h10, 1'b1);
        h0 = hs_cnt;
        repeat (10) tick();
        checks++;
        if (hs_cnt - h0 != 5) begin
            errors++;
            $display("FAIL rr_throughput: %0d packets in 10 cycles, required 5", hs_cnt - h0);
        end
        @(negedge clk);
        checks++;
        if (grant !== 5'b00000 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rr_bubble: grant=%b m_tvalid=%b, required 00000 0", grant, m_tvalid);
        end
        tick();
        tick();
        clr_all();
        check_sb_empty("rr_sb");
    endtask

    task automatic test_backpressure();
        do_reset();
        set_flit(1, 40'hA1, 1'b0);
        push_exp(1, 40'hA1, 1'b0);
        push_exp(1, 40'hA2, 1'b0);
        push_exp(1, 40'hA3, 1'b1);
        wait_hs(1, "bp_f1");
        set_flit(1, 40'hA2, 1'b0);
        m_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (m_tdata !== 40'hA2 || s_tready[1] !== 1'b0 || grant !== 5'b00010 || m_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall%0d: m_tdata=%h s_tready1=%b grant=%b m_tvalid=%b, required a2 0 00010 1",
                         c, m_tdata, s_tready[1], grant, m_tvalid);
            end
            tick();
        end
        m_tready = 1'b1;
        wait_hs(1, "bp_f2");
        set_flit(1, 40'hA3, 1'b1);
        wait_hs(1, "bp_f3");
        clr_all();
        check_sb_empty("bp_sb");
    endtask

    task automatic test_gap_competitor();
        do_reset();
        set_flit(3, 40'h31, 1'b0);
        push_exp(3, 40'h31, 1'b0);
        wait_hs(3, "gap_f1");
        s_tvalid[3] = 1'b0;
        set_flit(0, 40'h01, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== 5'b01000 || m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold%0d: grant=%b m_tvalid=%b, required 01000 0", c, grant, m_tvalid);
            end
            tick();
        end
        set_flit(3, 40'h32, 1'b1);
        push_exp(3, 40'h32, 1'b1);
        push_exp(0, 40'h01, 1'b1);
        wait_hs(3, "gap_f2");
        clr_port(3);
        @(negedge clk);
        tick();
        #2;
        checks++;
        if (grant !== 5'b00001) begin
            errors++;
            $display("FAIL gap_next_grant: grant=%b, required 00001", grant);
        end
        wait_hs(0, "gap_p0");
        clr_all();
        check_sb_empty("gap_sb");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_flit(2, 40'h2F, 1'b1);
        push_exp(2, 40'h2F, 1'b1);
        wait_hs(2, "rstmid_pre");
        clr_port(2);
        set_flit(3, 40'h41, 1'b0);
        push_exp(3, 40'h41, 1'b0);
        wait_hs(3, "rstmid_f1");
        set_flit(3, 40'h42, 1'b0);
        m_tready = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        m_tready = 1'b1;
        clr_port(3);
        @(negedge clk);
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: grant=%b busy=%b m_tvalid=%b, required 00000 0 0", grant, busy, m_tvalid);
        end
        check_sb_empty("rstmid_sb_flush");
        tick();
        // Pointer was 3 before reset; after reset port 1 must beat port 4.
        set_flit(1, 40'h51, 1'b1);
        set_flit(4, 40'h54, 1'b1);
        push_exp(1, 40'h51, 1'b1);
        @(negedge clk);
        tick();
        #2;
        checks++;
        if (grant !== 5'b00010) begin
            errors++;
            $display("FAIL rstmid_rr_ptr: grant=%b, required 00010", grant);
        end
        wait_hs(1, "rstmid_resume");
        clr_all();
        check_sb_empty("rstmid_sb");
    endtask

`ifdef NOC_ARB_PMU_EN
    task automatic test_pmu();
        do_reset();
        m_tready = 1'b0;
        set_flit(4, 40'h4A, 1'b1);
        push_exp(4, 40'h4A, 1'b1);
        push_exp(4, 40'h4A, 1'b1);
        // Bubble plus 5 locked cycles with m_tready low: 6 blocked cycles.
        repeat (6) tick();
        m_tready = 1'b1;
        // Transfer, arbitration bubble (one more stall), transfer.
        repeat (3) tick();
        clr_all();
        pmu_sel = 3'd4;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (pmu_stall !== 32'd7 || pmu_pkts !== 32'd2) begin
            errors++;
            $display("FAIL pmu_port4: stall=%0d pkts=%0d, required 7 2", pmu_stall, pmu_pkts);
        end
        tick();
        check_sb_empty("pmu_sb");
    endtask
`endif

    // Watchdog: never let the run hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        m_tready = 1'b1;
        pmu_sel  = 3'd0;
        req      = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst && m_tvalid && m_tready) begin
                        hs_cnt++;
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_extra_beat: got data=%h grant=%b, required no beat", m_tdata, grant);
                        end else begin
                            e = sb_q.pop_front();
                            if (m_tdata !== e.data || m_tlast !== e.last || grant !== (5'b00001 << e.port)) begin
                                errors++;
                                $display("FAIL sb_beat: got data=%h last=%b grant=%b, required data=%h last=%b port=%0d",
                                         m_tdata, m_tlast, grant, e.data, e.last, e.port);
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_single();
        test_all_rr();
        test_backpressure();
        test_gap_competitor();
        test_reset_mid();
`ifdef NOC_ARB_PMU_EN
        test_pmu();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
